// File: rtl/regfile_context_engine_if.sv
// Register file context engine bus: control, save/restore streams and the
// register file port. master = engine side, slave = environment side.
interface regfile_context_engine_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int RFILE_ADDR_WIDTH = 5
);
  logic                        saveStart;
  logic                        restoreStart;
  logic                        abort;
  logic                        busy;
  logic                        done;
  logic                        saveValid;
  logic                        saveReady;
  logic [DATA_WIDTH-1:0]       saveData;
  logic                        restoreValid;
  logic                        restoreReady;
  logic [DATA_WIDTH-1:0]       restoreData;
  logic [1:0]                  rfWriteMoveEnable;
  logic [RFILE_ADDR_WIDTH-1:0] rfWriteAddr;
  logic [DATA_WIDTH-1:0]       rfWriteData;
  logic [RFILE_ADDR_WIDTH-1:0] rfReadAddr;
  logic [DATA_WIDTH-1:0]       rfReadData;

  modport master (
    input  saveStart, restoreStart, abort, saveReady, restoreValid, restoreData, rfReadData,
    output busy, done, saveValid, saveData, restoreReady,
           rfWriteMoveEnable, rfWriteAddr, rfWriteData, rfReadAddr
  );

  modport slave (
    output saveStart, restoreStart, abort, saveReady, restoreValid, restoreData, rfReadData,
    input  busy, done, saveValid, saveData, restoreReady,
           rfWriteMoveEnable, rfWriteAddr, rfWriteData, rfReadAddr
  );
endinterface

// File: rtl/regfile_context_engine.sv
// Saves/restores the whole register file over valid/ready streams.
// Define REGFILE_CTX_SKIP_ZERO_EN to leave register 0 out of both sequences.
module regfile_context_engine #(
  parameter int DATA_WIDTH       = 32,
  parameter int RFILE_ADDR_WIDTH = 5,
  parameter int RAM_DEPTH        = 1 << RFILE_ADDR_WIDTH
) (
  input  logic                     clock,
  input  logic                     resetN,
  regfile_context_engine_if.master bus
);
  localparam int AW = RFILE_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
`ifdef REGFILE_CTX_SKIP_ZERO_EN
  localparam logic [AW-1:0] FIRST = AW'(1);
`else
  localparam logic [AW-1:0] FIRST = AW'(0);
`endif
  localparam logic [AW-1:0] LAST = AW'(RAM_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, SAVE_FETCH, SAVE_SEND, RESTORE, FINISH} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   index_q, index_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            save_valid_q, save_valid_d;
  logic [DW-1:0]   save_data_q, save_data_d;
  logic            restore_ready_q, restore_ready_d;
  logic [1:0]      wme_q, wme_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [AW-1:0]   raddr_q, raddr_d;

  wire last = (index_q == LAST);

  always_comb begin
    state_d         = state_q;
    index_d         = index_q;
    done_d          = 1'b0;
    save_valid_d    = save_valid_q;
    save_data_d     = save_data_q;
    restore_ready_d = restore_ready_q;
    wme_d           = 2'b00;
    waddr_d         = waddr_q;
    wdata_d         = wdata_q;
    raddr_d         = raddr_q;
    case (state_q)
      IDLE: begin
        if (bus.saveStart) begin
          state_d = SAVE_FETCH;
          index_d = FIRST;
          raddr_d = FIRST;
        end else if (bus.restoreStart) begin
          state_d         = RESTORE;
          index_d         = FIRST;
          restore_ready_d = 1'b1;
        end
      end
      SAVE_FETCH: begin
        save_data_d  = bus.rfReadData;
        save_valid_d = 1'b1;
        state_d      = SAVE_SEND;
      end
      SAVE_SEND: begin
        if (save_valid_q && bus.saveReady) begin
          save_valid_d = 1'b0;
          if (last) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + AW'(1);
            raddr_d = index_q + AW'(1);
            state_d = SAVE_FETCH;
          end
        end
      end
      RESTORE: begin
        if (bus.restoreValid && restore_ready_q) begin
          wme_d   = 2'b01;
          waddr_d = index_q;
          wdata_d = bus.restoreData;
          if (last) begin
            restore_ready_d = 1'b0;
            state_d         = FINISH;
            done_d          = 1'b1;
          end else begin
            index_d = index_q + AW'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort beats any handshake in the same cycle; an already-issued write stays on the port
    if (bus.abort && state_q != IDLE) begin
      state_d         = IDLE;
      save_valid_d    = 1'b0;
      restore_ready_d = 1'b0;
      wme_d           = 2'b00;
      done_d          = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q         <= IDLE;
      index_q         <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      save_valid_q    <= 1'b0;
      save_data_q     <= '0;
      restore_ready_q <= 1'b0;
      wme_q           <= 2'b00;
      waddr_q         <= '0;
      wdata_q         <= '0;
      raddr_q         <= '0;
    end else begin
      state_q         <= state_d;
      index_q         <= index_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      save_valid_q    <= save_valid_d;
      save_data_q     <= save_data_d;
      restore_ready_q <= restore_ready_d;
      wme_q           <= wme_d;
      waddr_q         <= waddr_d;
      wdata_q         <= wdata_d;
      raddr_q         <= raddr_d;
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.saveValid         = save_valid_q;
  assign bus.saveData          = save_data_q;
  assign bus.restoreReady      = restore_ready_q;
  assign bus.rfWriteMoveEnable = wme_q;
  assign bus.rfWriteAddr       = waddr_q;
  assign bus.rfWriteData       = wdata_q;
  assign bus.rfReadAddr        = raddr_q;
endmodule

// File: tb/tb_regfile_context_engine.sv
// Directed bench for regfile_context_engine with a falling-edge register file model.
module tb_regfile_context_engine;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
`ifdef REGFILE_CTX_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int WORDS = DEPTH - FIRST;

  logic clock;
  logic resetN;
  logic [DW-1:0] mem [DEPTH];
  int vec = 0;
  int err = 0;

  regfile_context_engine_if #(.DATA_WIDTH(DW), .RFILE_ADDR_WIDTH(AW)) bus ();

  regfile_context_engine #(.DATA_WIDTH(DW), .RFILE_ADDR_WIDTH(AW)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock)
    if (bus.rfWriteMoveEnable == 2'b01) mem[bus.rfWriteAddr] = bus.rfWriteData;

  assign bus.rfReadData = mem[bus.rfReadAddr];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) mem[i] = base + DW'(i);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.saveStart = 0; bus.restoreStart = 0; bus.abort = 0;
    bus.saveReady = 0; bus.restoreValid = 0; bus.restoreData = '0;
    #12;
    vec++;
    if ({bus.busy, bus.done, bus.saveValid, bus.restoreReady, bus.rfWriteMoveEnable,
         bus.saveData, bus.rfWriteData, bus.rfWriteAddr, bus.rfReadAddr} !== '0) begin
      err++;
      $display("FAIL reset_outputs: busy=%b done=%b sv=%b rr=%b wme=%b sd=%h wd=%h wa=%h ra=%h, want all 0",
               bus.busy, bus.done, bus.saveValid, bus.restoreReady, bus.rfWriteMoveEnable,
               bus.saveData, bus.rfWriteData, bus.rfWriteAddr, bus.rfReadAddr);
    end
    resetN = 1'b1;
    step();
    vec++;
    if (bus.busy !== 1'b0) begin err++; $display("FAIL reset_idle: busy=%b want 0", bus.busy); end
  endtask

  // stall: hold saveReady low 5 cycles on word 7; collide: restoreStart with saveStart and mid-save
  task automatic test_save(input string tag, input bit stall, input bit collide);
    int t, nw, ndone, first_v, done_t, stalls, order_bad, hold_bad, wme_bad, rr_bad;
    logic [DW-1:0] exp;
    preload(32'hA000_0000);
    t = 0; nw = 0; ndone = 0; first_v = -1; done_t = -1; stalls = 0;
    order_bad = 0; hold_bad = 0; wme_bad = 0; rr_bad = 0;
    bus.saveReady = 1'b1;
    bus.saveStart = 1'b1;
    bus.restoreStart = collide;
    step();
    bus.saveStart = 1'b0;
    bus.restoreStart = 1'b0;
    while (t < 400) begin
      step();
      t++;
      if (bus.rfWriteMoveEnable !== 2'b00) wme_bad++;
      if (bus.restoreReady !== 1'b0) rr_bad++;
      if (bus.done === 1'b1) begin ndone++; done_t = t; end
      if (bus.saveValid === 1'b1 && first_v < 0) first_v = t;
      bus.restoreStart = (collide && t == 20);
      if (bus.saveValid === 1'b1) begin
        exp = 32'hA000_0000 + DW'(FIRST + nw);
        if (stall && nw == 7 && stalls < 5) begin
          stalls++;
          bus.saveReady = 1'b0;
          if (bus.saveData !== exp) hold_bad++;
        end else begin
          bus.saveReady = 1'b1;
          if (bus.saveData !== exp) order_bad++;
          nw++;
        end
      end
      if (bus.busy === 1'b0) break;
    end
    bus.restoreStart = 1'b0;
    vec++; if (t >= 400) begin err++; $display("FAIL %s_timeout: cycles=%0d limit 400", tag, t); end
    vec++; if (nw !== WORDS) begin err++; $display("FAIL %s_count: words=%0d want %0d", tag, nw, WORDS); end
    vec++; if (order_bad !== 0) begin err++; $display("FAIL %s_order: bad=%0d want 0", tag, order_bad); end
    vec++; if (ndone !== 1) begin err++; $display("FAIL %s_done: pulses=%0d want 1", tag, ndone); end
    vec++; if (first_v !== 1) begin err++; $display("FAIL %s_latency: first valid at %0d want 1", tag, first_v); end
    vec++; if (t !== done_t + 1) begin err++; $display("FAIL %s_busy_fall: at %0d want %0d", tag, t, done_t + 1); end
    vec++; if (wme_bad !== 0) begin err++; $display("FAIL %s_wme: nonzero cycles=%0d want 0", tag, wme_bad); end
    vec++; if (rr_bad !== 0) begin err++; $display("FAIL %s_rready: high cycles=%0d want 0", tag, rr_bad); end
    if (stall) begin
      vec++; if (stalls !== 5 || hold_bad !== 0) begin
        err++; $display("FAIL %s_hold: stalls=%0d bad=%0d want 5 and 0", tag, stalls, hold_bad);
      end
    end else begin
      vec++; if (done_t !== 2 * WORDS) begin
        err++; $display("FAIL %s_throughput: done at %0d want %0d", tag, done_t, 2 * WORDS);
      end
    end
  endtask

  task automatic test_restore();
    int t, k, nwr, ndone, bad, gap;
    bit rdy_prev;
    logic [DW-1:0] exp0;
    preload(32'hA000_0000);
    t = 0; k = 0; nwr = 0; ndone = 0; bad = 0; gap = 0;
    bus.restoreStart = 1'b1;
    step();
    bus.restoreStart = 1'b0;
    vec++; if (bus.restoreReady !== 1'b1) begin err++; $display("FAIL restore_ready: got %b want 1", bus.restoreReady); end
    rdy_prev = bus.restoreReady;
    bus.restoreValid = 1'b1;
    bus.restoreData = 32'h5500_0000 + DW'(FIRST);
    while (t < 200) begin
      step();
      t++;
      if (bus.rfWriteMoveEnable === 2'b01) begin
        if (bus.rfWriteAddr !== AW'(FIRST + nwr) || bus.rfWriteData !== 32'h5500_0000 + DW'(FIRST + nwr)) bad++;
        nwr++;
      end else if (nwr > 0 && nwr < WORDS) gap++;
      if (bus.done === 1'b1) ndone++;
      if (bus.restoreValid && rdy_prev) begin
        k++;
        if (k < WORDS) bus.restoreData = 32'h5500_0000 + DW'(FIRST + k);
        else bus.restoreValid = 1'b0;
      end
      rdy_prev = bus.restoreReady;
      if (bus.busy === 1'b0) break;
    end
    bus.restoreValid = 1'b0;
    exp0 = (FIRST == 1) ? 32'hA000_0000 : 32'h5500_0000;
    vec++; if (t >= 200) begin err++; $display("FAIL restore_timeout: cycles=%0d limit 200", t); end
    vec++; if (nwr !== WORDS) begin err++; $display("FAIL restore_writes: %0d want %0d", nwr, WORDS); end
    vec++; if (bad !== 0) begin err++; $display("FAIL restore_addr_data: bad=%0d want 0", bad); end
    vec++; if (gap !== 0) begin err++; $display("FAIL restore_b2b: gaps=%0d want 0", gap); end
    vec++; if (ndone !== 1) begin err++; $display("FAIL restore_done: pulses=%0d want 1", ndone); end
    vec++; if (mem[31] !== 32'h5500_001F) begin err++; $display("FAIL restore_reg31: got %h want 5500001f", mem[31]); end
    vec++; if (mem[0] !== exp0) begin err++; $display("FAIL restore_reg0: got %h want %h", mem[0], exp0); end
  endtask

  task automatic test_abort_restore();
    int bad, dn;
    logic [DW-1:0] exp;
    preload(32'hA000_0000);
    bad = 0; dn = 0;
    bus.restoreStart = 1'b1;
    step();
    bus.restoreStart = 1'b0;
    bus.restoreValid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.restoreData = 32'h6600_0000 + DW'(FIRST + k);
      step();
    end
    bus.restoreValid = 1'b0;
    bus.abort = 1'b1;
    vec++; if (bus.rfWriteMoveEnable !== 2'b01 || bus.rfWriteAddr !== AW'(FIRST + 9)) begin
      err++; $display("FAIL abort_inflight: wme=%b addr=%0d want 01 %0d", bus.rfWriteMoveEnable, bus.rfWriteAddr, FIRST + 9);
    end
    step();
    bus.abort = 1'b0;
    vec++; if ({bus.busy, bus.restoreReady, bus.done, bus.rfWriteMoveEnable} !== 5'b0) begin
      err++; $display("FAIL abort_idle: busy=%b rr=%b done=%b wme=%b want all 0",
                      bus.busy, bus.restoreReady, bus.done, bus.rfWriteMoveEnable);
    end
    for (int i = 0; i < 3; i++) begin step(); if (bus.done !== 1'b0) dn++; end
    vec++; if (dn !== 0) begin err++; $display("FAIL abort_no_done: pulses=%0d want 0", dn); end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i >= FIRST && i < FIRST + 10) ? 32'h6600_0000 + DW'(i) : 32'hA000_0000 + DW'(i);
      if (mem[i] !== exp) bad++;
    end
    vec++; if (bad !== 0) begin err++; $display("FAIL abort_regs: wrong regs=%0d want 0", bad); end
  endtask

  task automatic test_reset_mid_save();
    preload(32'hA000_0000);
    bus.saveReady = 1'b1;
    bus.saveStart = 1'b1;
    step();
    bus.saveStart = 1'b0;
    for (int i = 0; i < 7; i++) step();
    #2;
    resetN = 1'b0;
    #1;
    vec++;
    if ({bus.busy, bus.done, bus.saveValid, bus.restoreReady, bus.rfWriteMoveEnable,
         bus.saveData, bus.rfWriteData, bus.rfWriteAddr, bus.rfReadAddr} !== '0) begin
      err++;
      $display("FAIL midsave_reset: busy=%b sv=%b sd=%h ra=%h, want all 0",
               bus.busy, bus.saveValid, bus.saveData, bus.rfReadAddr);
    end
    #5;
    resetN = 1'b1;
    step();
    vec++; if (bus.busy !== 1'b0 || bus.saveValid !== 1'b0) begin
      err++; $display("FAIL midsave_after: busy=%b sv=%b want 0 0", bus.busy, bus.saveValid);
    end
  endtask

  initial begin
    test_reset();
    test_save("save", 1'b0, 1'b0);
    test_save("stall", 1'b1, 1'b0);
    test_restore();
    test_save("collide", 1'b0, 1'b1);
    test_abort_restore();
    test_reset_mid_save();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
